// File: rtl/imm_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : imm_decode_stage
//  Description : Registered, handshaked immediate generator placed between
//                fetch and decode/execute. It extracts the I/S/B/U/J
//                immediates (sign-extended to XLEN), the CSR zimm and the
//                shift amount (zero-extended) from a 32-bit instruction.
//                A three-state pipeline register with a skid buffer keeps
//                full throughput under backpressure. An opaque sideband tag
//                travels with every beat.
//
//  Optional feature (compile-time macro IMMDEC_AUTODECODE_EN):
//                When defined, the ImmSrc port is ignored and the immediate
//                kind is derived from the opcode and funct3 of instr_d.
//                When undefined, ImmSrc selects the kind directly.
//
//  Parameters  : XLEN  - datapath width, 32 or 64
//                TAG_W - sideband width
//
//  Ports       : clk        in   clock, rising edge
//                rst        in   synchronous active-high reset
//                flush      in   drop every held beat
//                in_valid   in   upstream beat valid
//                in_ready   out  stage can accept a beat
//                instr_d    in   32-bit instruction word
//                ImmSrc     in   immediate kind (000 none .. 111 shamt)
//                tag_in     in   sideband, passed through unchanged
//                out_valid  out  output beat valid
//                out_ready  in   downstream accepts
//                imm        out  extended immediate
//                tag_out    out  sideband matching imm
//                imm_err    out  illegal shift amount for XLEN
//
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_decode_stage #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr_d,
    input  logic [2:0]       ImmSrc,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [TAG_W-1:0] tag_out,
    output logic             imm_err
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter check
    // ------------------------------------------------------------------------
    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_decode_stage: XLEN must be 32 or 64");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Immediate kind encodings
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_SRC_NONE = 3'b000;
    localparam logic [2:0] c_SRC_I    = 3'b001;
    localparam logic [2:0] c_SRC_S    = 3'b010;
    localparam logic [2:0] c_SRC_B    = 3'b011;
    localparam logic [2:0] c_SRC_U    = 3'b100;
    localparam logic [2:0] c_SRC_J    = 3'b101;
    localparam logic [2:0] c_SRC_Z    = 3'b110;
    localparam logic [2:0] c_SRC_SH   = 3'b111;

    // ------------------------------------------------------------------------
    // Handshake state
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_SKID  = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [XLEN-1:0]   r_out_imm;
    logic [TAG_W-1:0]  r_out_tag;
    logic              r_out_err;
    logic [XLEN-1:0]   r_skid_imm;
    logic [TAG_W-1:0]  r_skid_tag;
    logic              r_skid_err;

    logic              w_in_fire;
    logic              w_out_fire;

    // ------------------------------------------------------------------------
    // Immediate kind selection
    // ------------------------------------------------------------------------
    logic [2:0]        w_src;
    // Set for the 32-bit word shifts (slliw/srliw/sraiw): always a 5-bit
    // shift amount, with bit 25 flagged as illegal.
    logic              w_sh_w;

`ifdef IMMDEC_AUTODECODE_EN
    logic [6:0]        w_opcode;
    logic [2:0]        w_funct3;
    logic              w_unused_immsrc;

    assign w_opcode        = instr_d[6:0];
    assign w_funct3        = instr_d[14:12];
    assign w_unused_immsrc = ^ImmSrc;

    always_comb begin
        w_src  = c_SRC_NONE;
        w_sh_w = 1'b0;
        case (w_opcode)
            7'b0000011,
            7'b1100111: w_src = c_SRC_I;
            7'b0010011: begin
                if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                    w_src = c_SRC_SH;
                end else begin
                    w_src = c_SRC_I;
                end
            end
            7'b0011011: begin
                // The *W opcode space does not exist on RV32.
                if (XLEN == 64) begin
                    if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                        w_src  = c_SRC_SH;
                        w_sh_w = 1'b1;
                    end else begin
                        w_src = c_SRC_I;
                    end
                end
            end
            7'b0100011: w_src = c_SRC_S;
            7'b1100011: w_src = c_SRC_B;
            7'b0110111,
            7'b0010111: w_src = c_SRC_U;
            7'b1101111: w_src = c_SRC_J;
            7'b1110011: begin
                if (w_funct3[2]) begin
                    w_src = c_SRC_Z;
                end else begin
                    w_src = c_SRC_I;
                end
            end
            default:    w_src = c_SRC_NONE;
        endcase
    end
`else
    logic              w_unused_opcode;

    assign w_src           = ImmSrc;
    assign w_sh_w          = 1'b0;
    assign w_unused_opcode = ^instr_d[6:0];
`endif

    // ------------------------------------------------------------------------
    // Immediate formation
    // ------------------------------------------------------------------------
    // Every form is first built as a 32-bit value whose bit 31 is the
    // extension bit: sign-extended forms carry instr[31] there, zimm and
    // shamt carry 0. Widening to XLEN then only replicates bit 31.
    logic [31:0]       w_imm32;
    logic [XLEN-1:0]   w_imm;
    logic              w_err;

    always_comb begin
        w_imm32 = 32'd0;
        w_err   = 1'b0;
        case (w_src)
            c_SRC_I:  w_imm32 = {{20{instr_d[31]}}, instr_d[31:20]};
            c_SRC_S:  w_imm32 = {{20{instr_d[31]}}, instr_d[31:25],
                                 instr_d[11:7]};
            c_SRC_B:  w_imm32 = {{19{instr_d[31]}}, instr_d[31], instr_d[7],
                                 instr_d[30:25], instr_d[11:8], 1'b0};
            c_SRC_U:  w_imm32 = {instr_d[31:12], 12'd0};
            c_SRC_J:  w_imm32 = {{11{instr_d[31]}}, instr_d[31],
                                 instr_d[19:12], instr_d[20],
                                 instr_d[30:21], 1'b0};
            c_SRC_Z:  w_imm32 = {27'd0, instr_d[19:15]};
            c_SRC_SH: begin
                if (XLEN == 64 && !w_sh_w) begin
                    w_imm32 = {26'd0, instr_d[25:20]};
                end else begin
                    // Only 5 shift bits are legal; bit 25 set is an error.
                    w_imm32 = {27'd0, instr_d[24:20]};
                    w_err   = instr_d[25];
                end
            end
            default:  w_imm32 = 32'd0;
        endcase
    end

    always_comb begin
        w_imm       = {XLEN{w_imm32[31]}};
        w_imm[31:0] = w_imm32;
    end

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    // in_ready is a pure function of the registered state; reset only masks
    // it so no beat can be accepted while the stage is being cleared.
    assign in_ready   = r_in_ready & ~rst;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_imm   <= '0;
            r_out_tag   <= '0;
            r_out_err   <= 1'b0;
            r_skid_imm  <= '0;
            r_skid_tag  <= '0;
            r_skid_err  <= 1'b0;
        end else if (flush) begin
            // Any beat offered this cycle is dropped along with held ones.
            r_state     <= S_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_fire) begin
                        r_out_imm   <= w_imm;
                        r_out_tag   <= tag_in;
                        r_out_err   <= w_err;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (w_in_fire && w_out_fire) begin
                        r_out_imm <= w_imm;
                        r_out_tag <= tag_in;
                        r_out_err <= w_err;
                    end else if (w_in_fire) begin
                        // Output is stalled; park the new beat behind it.
                        r_skid_imm <= w_imm;
                        r_skid_tag <= tag_in;
                        r_skid_err <= w_err;
                        r_in_ready <= 1'b0;
                        r_state    <= S_SKID;
                    end else if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_EMPTY;
                    end
                end
                S_SKID: begin
                    if (w_out_fire) begin
                        r_out_imm  <= r_skid_imm;
                        r_out_tag  <= r_skid_tag;
                        r_out_err  <= r_skid_err;
                        r_in_ready <= 1'b1;
                        r_state    <= S_FULL;
                    end
                end
                default: begin
                    r_state     <= S_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign imm       = r_out_imm;
    assign tag_out   = r_out_tag;
    assign imm_err   = r_out_err;

endmodule
`default_nettype wire
